alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares the single combinational ALU between N_REQ requesters (fetch/decode unit, load/store helper, ...).
//  Per requester: valid/ready request handshake and valid/ready response handshake.
//  Round-robin grant, registered ALU operands, registered result.
//  Sits between the requesters and the ALU instance; the ALU itself is unchanged.
// PARAMETERS
//  N_REQ  2  number of requesters (2..4)
//  W      8  datapath width (matches ALU InputA/InputB/Out)
//  OPW    3  ALU opcode width
// PORTS
//  CLK        in   1        clock, rising edge
//  Reset_n    in   1        asynchronous, active-low reset
//  Req_valid  in   N_REQ    request pending, one bit per requester
//  Req_ready  out  N_REQ    request accepted this cycle (one-hot or zero)
//  Req_op     in   N_REQ*OPW  opcode, requester i in slice [i*OPW +: OPW]
//  Req_A      in   N_REQ*W  operand A, slice [i*W +: W]
//  Req_B      in   N_REQ*W  operand B, slice [i*W +: W]
//  Rsp_valid  out  N_REQ    result available for requester i (one-hot or zero)
//  Rsp_ready  in   N_REQ    requester i consumes the result
//  Rsp_data   out  W        result, shared bus, valid when any Rsp_valid
//  Rsp_zero   out  1        ALU Zero flag captured with Rsp_data
//  AluA       out  W        to ALU InputA (registered)
//  AluB       out  W        to ALU InputB (registered)
//  AluOp      out  OPW      to ALU OP (registered)
//  AluSc      out  1        to ALU SC_in, constant 0
//  AluOut     in   W        from ALU Out
//  AluZero    in   1        from ALU Zero
//  Busy       out  1        state != IDLE
// BEHAVIOUR
//  Reset (async, Reset_n=0): state=IDLE; rr_ptr=0; AluA/AluB/AluOp/Rsp_data/Rsp_zero=0; Rsp_valid=0; Busy=0.
//  Reset (cont.): Req_ready=0 while Reset_n=0. Reset mid-transaction drops it silently; no response is issued.
//  FSM: IDLE -> EXEC -> RESP -> IDLE. No other transitions.
//   IDLE: winner g = first i with Req_valid[i], searching from rr_ptr upward mod N_REQ.
//         Req_ready[g]=1 combinationally (only in IDLE, only the winner).
//         Handshake (valid&ready) latches AluA/AluB/AluOp from slice g and latches gnt=g; go to EXEC.
//         No Req_valid -> stay in IDLE.
//   EXEC: ALU settles on the registered operands. At the clock edge, Rsp_data<=AluOut, Rsp_zero<=AluZero; go to RESP.
//   RESP: Rsp_valid[gnt]=1; Rsp_data/Rsp_zero held stable.
//         On Rsp_ready[gnt]: rr_ptr<=(gnt+1) mod N_REQ; go to IDLE.
//         Rsp_ready of non-granted requesters ignored.
//  Latency: handshake edge T -> result registered at T+1 -> Rsp_valid high during cycle T+2.
//  Throughput: 1 op per 3 cycles minimum.
//  Req_ready is 0 in EXEC/RESP. A requester holds valid and operands until accepted; operands may change after acceptance.
//  Simultaneous requests: round-robin. A requester just served has lowest priority next time. No starvation: wait <= N_REQ grants.
//  Widths: all arithmetic is done in the ALU; the arbiter never modifies data. rr_ptr is $clog2(N_REQ) bits and wraps N_REQ-1 -> 0.
//  AluA/AluB/AluOp keep the last issued values after the transaction (no toggling while idle).
// STRUCTURE
//  Shared package definitions:
//   - ALU op constants ADD=000 RXOR=001 OR=010 LOAD=011 STORE=100 BGTZ=101 SLL=110 AND=111
//   - typedef enum logic[1:0] {IDLE, EXEC, RESP} arb_state_t
//  Sub-module rr_pick: combinational; inputs req[N_REQ] and ptr; outputs one-hot grant and index.
//  FSM, operand/result registers and rr_ptr live in alu_arbiter.
// TESTING (bench instantiates alu_arbiter + ALU, N_REQ=2)
//  1 Reset: Reset_n=0 mid-EXEC -> all outputs 0 immediately; after release, no Rsp_valid appears.
//  2 Single: req0 ADD A=8'h05 B=8'h03 at T -> Rsp_valid[0] at T+2, Rsp_data=8'h08, Rsp_zero per ALU.
//  3 Contention: req0 and req1 held high continuously, rr_ptr=0 -> grants alternate 0,1,0,1 and each result goes to the correct Rsp_valid bit.
//  4 Backpressure: Rsp_ready[1]=0 for 5 cycles in RESP -> Rsp_valid[1] and Rsp_data stay stable; Req_ready stays 0; Busy=1.
//  5 Wrong consumer: in RESP for gnt=0, Rsp_ready=2'b10 -> no state change; then Rsp_ready=2'b01 -> back to IDLE.
//  6 Sweep: AND A=8'hF0 B=8'h3C -> 8'h30; OR -> 8'hFC; SLL A=8'h01 B=8'h03 -> 8'h08; ADD 8'hFF+8'h01 -> 8'h00 (wrap).

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: ALU opcodes, FSM state type and a
// round-robin wrap helper.
package alu_arbiter_pkg;

  localparam int unsigned ALU_OPW = 3;

  // ALU opcode encodings (the ALU itself decodes these; the arbiter only forwards them)
  localparam logic [ALU_OPW-1:0] OP_ADD   = 3'b000;
  localparam logic [ALU_OPW-1:0] OP_RXOR  = 3'b001;
  localparam logic [ALU_OPW-1:0] OP_OR    = 3'b010;
  localparam logic [ALU_OPW-1:0] OP_LOAD  = 3'b011;
  localparam logic [ALU_OPW-1:0] OP_STORE = 3'b100;
  localparam logic [ALU_OPW-1:0] OP_BGTZ  = 3'b101;
  localparam logic [ALU_OPW-1:0] OP_SLL   = 3'b110;
  localparam logic [ALU_OPW-1:0] OP_AND   = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t;

  // (v + 1) mod n for v < n
  function automatic int unsigned rr_wrap_inc(input int unsigned v, input int unsigned n);
    return ((v + 32'd1) >= n) ? 32'd0 : (v + 32'd1);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester and ALU-side bus of the ALU arbiter.
//   Req_*  : per-requester request handshake, operands packed i*W / i*OPW
//   Rsp_*  : per-requester response handshake, shared result bus
//   Alu*   : registered operands to the ALU and its combinational result
//   Busy   : arbiter not idle
// slave  = arbiter side, master = requesters/ALU side.
interface alu_arbiter_if #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned W     = 8,
  parameter int unsigned OPW   = 3
);
  logic [N_REQ-1:0]     Req_valid;
  logic [N_REQ-1:0]     Req_ready;
  logic [N_REQ*OPW-1:0] Req_op;
  logic [N_REQ*W-1:0]   Req_A;
  logic [N_REQ*W-1:0]   Req_B;
  logic [N_REQ-1:0]     Rsp_valid;
  logic [N_REQ-1:0]     Rsp_ready;
  logic [W-1:0]         Rsp_data;
  logic                 Rsp_zero;
  logic [W-1:0]         AluA;
  logic [W-1:0]         AluB;
  logic [OPW-1:0]       AluOp;
  logic                 AluSc;
  logic [W-1:0]         AluOut;
  logic                 AluZero;
  logic                 Busy;

  modport slave (
    input  Req_valid, Req_op, Req_A, Req_B, Rsp_ready, AluOut, AluZero,
    output Req_ready, Rsp_valid, Rsp_data, Rsp_zero, AluA, AluB, AluOp, AluSc, Busy
  );

  modport master (
    output Req_valid, Req_op, Req_A, Req_B, Rsp_ready, AluOut, AluZero,
    input  Req_ready, Rsp_valid, Rsp_data, Rsp_zero, AluA, AluB, AluOp, AluSc, Busy
  );
endinterface

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req_i searching upward
// from ptr_i modulo N_REQ.
//   req_i      : request vector
//   ptr_i      : highest-priority index
//   grant_c_o  : one-hot winner (zero when no request)
//   idx_c_o    : winner index
//   any_c_o    : at least one request present
module alu_arbiter_rr_pick #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned PW    = 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PW-1:0]    ptr_i,
  output logic [N_REQ-1:0] grant_c_o,
  output logic [PW-1:0]    idx_c_o,
  output logic             any_c_o
);

  int unsigned   pos;
  logic [PW-1:0] pos_idx;

  always_comb begin
    grant_c_o = '0;
    idx_c_o   = '0;
    any_c_o   = 1'b0;
    pos       = 32'd0;
    pos_idx   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      pos     = (32'(ptr_i) + k) % N_REQ;
      pos_idx = PW'(pos);
      if (!any_c_o && req_i[pos_idx]) begin
        any_c_o            = 1'b1;
        idx_c_o            = pos_idx;
        grant_c_o[pos_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between N_REQ requesters with round-robin
// arbitration, registered ALU operands and a registered result.
//   CLK, Reset_n : clock (rising edge), asynchronous active-low reset
//   bus (slave)  : request/response handshakes and the ALU connection
// Transaction: IDLE (accept) -> EXEC (ALU settles) -> RESP (hold result).
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned W     = 8,
  parameter int unsigned OPW   = 3
) (
  input  logic         CLK,
  input  logic         Reset_n,
  alu_arbiter_if.slave bus
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t     state_q, state_d;
  logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]  gnt_q, gnt_d;
  logic [W-1:0]   alu_a_q, alu_a_d;
  logic [W-1:0]   alu_b_q, alu_b_d;
  logic [OPW-1:0] alu_op_q, alu_op_d;
  logic [W-1:0]   rsp_data_q, rsp_data_d;
  logic           rsp_zero_q, rsp_zero_d;

  logic [N_REQ-1:0] pick_oh_c;
  logic [PW-1:0]    pick_idx_c;
  logic             pick_any_c;
  logic [N_REQ-1:0] req_ready_c;
  logic [N_REQ-1:0] rsp_valid_c;

  alu_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_rr_pick (
    .req_i     (bus.Req_valid),
    .ptr_i     (rr_ptr_q),
    .grant_c_o (pick_oh_c),
    .idx_c_o   (pick_idx_c),
    .any_c_o   (pick_any_c)
  );

  // State, pointer, operand and result registers
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      rsp_data_q <= '0;
      rsp_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_q      <= gnt_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      rsp_data_q <= rsp_data_d;
      rsp_zero_q <= rsp_zero_d;
    end
  end

  // Next-state and handshake decode
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rsp_data_d  = rsp_data_q;
    rsp_zero_d  = rsp_zero_q;
    req_ready_c = '0;
    rsp_valid_c = '0;

    case (state_q)
      IDLE: begin
        // The picked requester is by construction valid, so ready implies handshake
        req_ready_c = pick_oh_c;
        if (pick_any_c) begin
          alu_a_d  = bus.Req_A[32'(pick_idx_c)*W +: W];
          alu_b_d  = bus.Req_B[32'(pick_idx_c)*W +: W];
          alu_op_d = bus.Req_op[32'(pick_idx_c)*OPW +: OPW];
          gnt_d    = pick_idx_c;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d = bus.AluOut;
        rsp_zero_d = bus.AluZero;
        state_d    = RESP;
      end
      RESP: begin
        rsp_valid_c[gnt_q] = 1'b1;
        // Only the granted requester can retire the response
        if (bus.Rsp_ready[gnt_q]) begin
          rr_ptr_d = PW'(rr_wrap_inc(32'(gnt_q), N_REQ));
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Req_ready is combinational; masked so nothing is accepted while in reset
  assign bus.Req_ready = Reset_n ? req_ready_c : '0;
  assign bus.Rsp_valid = rsp_valid_c;
  assign bus.Rsp_data  = rsp_data_q;
  assign bus.Rsp_zero  = rsp_zero_q;
  assign bus.AluA      = alu_a_q;
  assign bus.AluB      = alu_b_q;
  assign bus.AluOp     = alu_op_q;
  assign bus.AluSc     = 1'b0;
  assign bus.Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter (N_REQ=2) with a behavioural ALU model.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int unsigned N_REQ = 2;
  localparam int unsigned W     = 8;
  localparam int unsigned OPW   = 3;

  logic CLK;
  logic Reset_n;
  int unsigned n_checks;
  int unsigned n_errors;

  alu_arbiter_if #(.N_REQ(N_REQ), .W(W), .OPW(OPW)) bus();

  alu_arbiter #(.N_REQ(N_REQ), .W(W), .OPW(OPW)) dut (
    .CLK     (CLK),
    .Reset_n (Reset_n),
    .bus     (bus.slave)
  );

  // Behavioural ALU
  logic [W-1:0] alu_out;
  always_comb begin
    alu_out = '0;
    case (bus.AluOp)
      OP_ADD:   alu_out = bus.AluA + bus.AluB + {7'd0, bus.AluSc};
      OP_RXOR:  alu_out = {7'd0, ^bus.AluA};
      OP_OR:    alu_out = bus.AluA | bus.AluB;
      OP_LOAD:  alu_out = bus.AluB;
      OP_STORE: alu_out = bus.AluA;
      OP_BGTZ:  alu_out = ($signed(bus.AluA) > 0) ? 8'd1 : 8'd0;
      OP_SLL:   alu_out = bus.AluA << bus.AluB[2:0];
      OP_AND:   alu_out = bus.AluA & bus.AluB;
      default:  alu_out = '0;
    endcase
  end
  assign bus.AluOut  = alu_out;
  assign bus.AluZero = (alu_out == '0);

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input int r, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.Req_op[r*OPW +: OPW] = op;
    bus.Req_A[r*W +: W]      = a;
    bus.Req_B[r*W +: W]      = b;
    bus.Req_valid[r]         = 1'b1;
  endtask

  // One complete transaction for requester r with no competing requests
  task automatic do_txn(input string tag, input int r, input logic [2:0] op,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_d, input logic exp_z);
    logic ok;
    ok = 1'b0;
    @(negedge CLK);
    drive_req(r, op, a, b);
    for (int i = 0; i < 8; i++) begin
      #1;
      if (bus.Req_ready[r]) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    check({tag, " accept"}, 32'(ok), 32'd1);
    if (!ok) begin
      bus.Req_valid[r] = 1'b0;
      return;
    end
    @(posedge CLK);
    @(negedge CLK);
    bus.Req_valid[r] = 1'b0;
    check({tag, " exec busy"}, 32'(bus.Busy), 32'd1);
    check({tag, " exec rsp_valid"}, 32'(bus.Rsp_valid), 32'd0);
    check({tag, " alu_a"}, 32'(bus.AluA), 32'(a));
    check({tag, " alu_b"}, 32'(bus.AluB), 32'(b));
    check({tag, " alu_op"}, 32'(bus.AluOp), 32'(op));
    @(negedge CLK);
    check({tag, " rsp_valid"}, 32'(bus.Rsp_valid), 32'd1 << r);
    check({tag, " rsp_data"}, 32'(bus.Rsp_data), 32'(exp_d));
    check({tag, " rsp_zero"}, 32'(bus.Rsp_zero), 32'(exp_z));
    bus.Rsp_ready[r] = 1'b1;
    @(negedge CLK);
    check({tag, " idle busy"}, 32'(bus.Busy), 32'd0);
    check({tag, " idle rsp_valid"}, 32'(bus.Rsp_valid), 32'd0);
    bus.Rsp_ready[r] = 1'b0;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    repeat (2) @(negedge CLK);
    Reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    n_checks      = 0;
    n_errors      = 0;
    Reset_n       = 1'b0;
    bus.Req_valid = '0;
    bus.Req_op    = '0;
    bus.Req_A     = '0;
    bus.Req_B     = '0;
    bus.Rsp_ready = '0;

    // Reset state, with requests pending to exercise Req_ready masking
    repeat (2) @(negedge CLK);
    bus.Req_valid = 2'b11;
    #1;
    check("rst req_ready", 32'(bus.Req_ready), 32'd0);
    check("rst busy", 32'(bus.Busy), 32'd0);
    check("rst rsp_valid", 32'(bus.Rsp_valid), 32'd0);
    check("rst alu_a", 32'(bus.AluA), 32'd0);
    check("rst alu_b", 32'(bus.AluB), 32'd0);
    check("rst alu_op", 32'(bus.AluOp), 32'd0);
    check("rst rsp_data", 32'(bus.Rsp_data), 32'd0);
    check("rst rsp_zero", 32'(bus.Rsp_zero), 32'd0);
    check("rst alu_sc", 32'(bus.AluSc), 32'd0);
    bus.Req_valid = 2'b00;
    @(negedge CLK);
    Reset_n = 1'b1;

    // Single request with latency checks
    do_txn("single", 0, OP_ADD, 8'h05, 8'h03, 8'h08, 1'b0);

    // Operation sweep
    do_txn("and",  0, OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0);
    do_txn("or",   0, OP_OR,  8'hF0, 8'h3C, 8'hFC, 1'b0);
    do_txn("sll",  0, OP_SLL, 8'h01, 8'h03, 8'h08, 1'b0);
    do_txn("wrap", 0, OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b1);

    // Contention from rr_ptr=0: grants alternate 0,1,0,1
    do_reset();
    @(negedge CLK);
    bus.Rsp_ready = 2'b11;
    drive_req(0, OP_ADD, 8'h01, 8'h02);
    drive_req(1, OP_OR,  8'h10, 8'h01);
    for (int g = 0; g < 4; g++) begin
      w = g % 2;
      #1;
      check("cont req_ready", 32'(bus.Req_ready), 32'd1 << w);
      @(negedge CLK);
      check("cont busy", 32'(bus.Busy), 32'd1);
      @(negedge CLK);
      check("cont rsp_valid", 32'(bus.Rsp_valid), 32'd1 << w);
      check("cont rsp_data", 32'(bus.Rsp_data), (w == 0) ? 32'h03 : 32'h11);
      @(negedge CLK);
    end
    bus.Req_valid = 2'b00;
    bus.Rsp_ready = 2'b00;

    // Backpressure on requester 1 while requester 0 waits
    @(negedge CLK);
    drive_req(1, OP_ADD, 8'h20, 8'h22);
    #1;
    check("bp req_ready", 32'(bus.Req_ready), 32'd2);
    @(posedge CLK);
    @(negedge CLK);
    bus.Req_valid = 2'b00;
    @(negedge CLK);
    drive_req(0, OP_ADD, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp rsp_valid", 32'(bus.Rsp_valid), 32'd2);
      check("bp rsp_data", 32'(bus.Rsp_data), 32'h42);
      check("bp req_ready", 32'(bus.Req_ready), 32'd0);
      check("bp busy", 32'(bus.Busy), 32'd1);
      @(negedge CLK);
    end
    bus.Rsp_ready = 2'b10;
    @(negedge CLK);
    bus.Rsp_ready = 2'b00;
    #1;
    check("bp release busy", 32'(bus.Busy), 32'd0);
    check("rr after 1 ready", 32'(bus.Req_ready), 32'd1);

    // Wrong consumer: requester 1 cannot retire requester 0's response
    @(posedge CLK);
    @(negedge CLK);
    bus.Req_valid = 2'b00;
    @(negedge CLK);
    check("wc rsp_valid", 32'(bus.Rsp_valid), 32'd1);
    check("wc rsp_data", 32'(bus.Rsp_data), 32'h00);
    check("wc rsp_zero", 32'(bus.Rsp_zero), 32'd1);
    bus.Rsp_ready = 2'b10;
    repeat (3) begin
      @(negedge CLK);
      check("wc hold rsp_valid", 32'(bus.Rsp_valid), 32'd1);
      check("wc hold busy", 32'(bus.Busy), 32'd1);
    end
    bus.Rsp_ready = 2'b01;
    @(negedge CLK);
    bus.Rsp_ready = 2'b00;
    check("wc done busy", 32'(bus.Busy), 32'd0);
    check("wc done rsp_valid", 32'(bus.Rsp_valid), 32'd0);

    // Leave a non-zero result in the registers before the reset test
    do_txn("pre", 1, OP_OR, 8'h0F, 8'hA0, 8'hAF, 1'b0);

    // Reset asserted mid-EXEC
    @(negedge CLK);
    drive_req(0, OP_SLL, 8'h01, 8'h02);
    #1;
    check("mid req_ready", 32'(bus.Req_ready), 32'd1);
    @(posedge CLK);
    @(negedge CLK);
    check("mid busy", 32'(bus.Busy), 32'd1);
    Reset_n = 1'b0;
    #1;
    check("mid rst busy", 32'(bus.Busy), 32'd0);
    check("mid rst req_ready", 32'(bus.Req_ready), 32'd0);
    check("mid rst rsp_valid", 32'(bus.Rsp_valid), 32'd0);
    check("mid rst alu_a", 32'(bus.AluA), 32'd0);
    check("mid rst alu_b", 32'(bus.AluB), 32'd0);
    check("mid rst alu_op", 32'(bus.AluOp), 32'd0);
    check("mid rst rsp_data", 32'(bus.Rsp_data), 32'd0);
    check("mid rst rsp_zero", 32'(bus.Rsp_zero), 32'd0);
    bus.Req_valid = 2'b00;
    @(negedge CLK);
    Reset_n = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      check("post rst rsp_valid", 32'(bus.Rsp_valid), 32'd0);
      check("post rst busy", 32'(bus.Busy), 32'd0);
    end

    do_txn("post", 1, OP_AND, 8'hAA, 8'h0F, 8'h0A, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
